// File: rtl/lcd_char_feeder_if.sv
// Handshake between the ALU result source and the LCD character feeder.
// The master drives result strobes; the slave (feeder) returns characters and status.
interface lcd_char_feeder_if;
   logic       iValid;
   logic [7:0] iData;
   logic       iMode;
   logic [7:0] oChar;
   logic       oCharValid;
   logic       oBusy;
   logic       oDropped;

   modport master (
      output iValid, iData, iMode,
      input  oChar, oCharValid, oBusy, oDropped
   );

   modport slave (
      input  iValid, iData, iMode,
      output oChar, oCharValid, oBusy, oDropped
   );
endinterface

// File: rtl/lcd_char_feeder.sv
// Converts each 8-bit ALU result to ASCII (3 decimal or 2 hex digits, optional space)
// and paces the characters to an LCD controller that has no ready handshake.
module lcd_char_feeder #(
   parameter int unsigned STARTUP_CYCLES = 1000000,
   parameter int unsigned GAP_CYCLES     = 100000,
   parameter bit          APPEND_SPACE   = 1'b1
) (
   input logic             Clock,
   input logic             Reset,
   lcd_char_feeder_if.slave bus
);

   localparam logic [7:0] SPACE = 8'h20;

   typedef enum logic [2:0] {
      ST_STARTUP,
      ST_IDLE,
      ST_CONVERT,
      ST_EMIT,
      ST_GAP
   } state_t;

   state_t      state_q;
   logic [31:0] cnt_q;
   logic [2:0]  bit_q;
   logic [7:0]  sh_q;
   logic [11:0] bcd_q;
   logic [7:0]  data_q;
   logic        mode_q;
   logic [1:0]  idx_q;
   logic [1:0]  last_q;
   logic [7:0]  chars_q [4];
   logic [7:0]  oChar_q;
   logic        oCharValid_q;
   logic        oBusy_q;

   logic [19:0] dabble;
   logic [11:0] bcd_d;
   logic [7:0]  sh_d;
   logic [7:0]  chars_d [4];
   logic [1:0]  last_d;

   function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
      logic [11:0] r;
      r = b;
      for (int k = 0; k < 3; k++) begin
         if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [7:0] dec_ascii(input logic [3:0] n);
      return {4'h3, n};
   endfunction

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
   endfunction

   // One double-dabble step; on the last step bcd_d already holds the final digits.
   always_comb begin
      dabble = {dabble_adjust(bcd_q), sh_q} << 1;
      bcd_d  = dabble[19:8];
      sh_d   = dabble[7:0];
      for (int k = 0; k < 4; k++) chars_d[k] = SPACE;
      if (mode_q) begin
         chars_d[0] = hex_ascii(data_q[7:4]);
         chars_d[1] = hex_ascii(data_q[3:0]);
         last_d     = APPEND_SPACE ? 2'd2 : 2'd1;
      end else begin
         chars_d[0] = dec_ascii(bcd_d[11:8]);
         chars_d[1] = dec_ascii(bcd_d[7:4]);
         chars_d[2] = dec_ascii(bcd_d[3:0]);
         last_d     = APPEND_SPACE ? 2'd3 : 2'd2;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= ST_STARTUP;
         cnt_q        <= '0;
         bit_q        <= '0;
         sh_q         <= '0;
         bcd_q        <= '0;
         data_q       <= '0;
         mode_q       <= 1'b0;
         idx_q        <= '0;
         last_q       <= '0;
         for (int k = 0; k < 4; k++) chars_q[k] <= '0;
         oChar_q      <= '0;
         oCharValid_q <= 1'b0;
         oBusy_q      <= 1'b1;
      end else begin
         oCharValid_q <= 1'b0;
         case (state_q)
            ST_STARTUP: begin
               if (cnt_q == 32'(STARTUP_CYCLES - 1)) begin
                  cnt_q   <= '0;
                  oBusy_q <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            ST_IDLE: begin
               if (bus.iValid) begin
                  data_q  <= bus.iData;
                  mode_q  <= bus.iMode;
                  sh_q    <= bus.iData;
                  bcd_q   <= '0;
                  bit_q   <= '0;
                  oBusy_q <= 1'b1;
                  state_q <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               sh_q  <= sh_d;
               bcd_q <= bcd_d;
               bit_q <= bit_q + 3'd1;
               // The pulse is registered on entry to EMIT so it is high exactly while in EMIT.
               if (bit_q == 3'd7) begin
                  chars_q      <= chars_d;
                  last_q       <= last_d;
                  idx_q        <= '0;
                  oChar_q      <= chars_d[0];
                  oCharValid_q <= 1'b1;
                  state_q      <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               cnt_q   <= '0;
               state_q <= ST_GAP;
            end
            ST_GAP: begin
               if (cnt_q == 32'(GAP_CYCLES - 1)) begin
                  cnt_q <= '0;
                  if (idx_q < last_q) begin
                     idx_q        <= idx_q + 2'd1;
                     oChar_q      <= chars_q[idx_q + 2'd1];
                     oCharValid_q <= 1'b1;
                     state_q      <= ST_EMIT;
                  end else begin
                     oBusy_q <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            default: state_q <= ST_STARTUP;
         endcase
      end
   end

   // oBusy_q mirrors "state != IDLE", so a strobe on the return-to-IDLE cycle is dropped too.
   assign bus.oDropped   = bus.iValid & oBusy_q;
   assign bus.oChar      = oChar_q;
   assign bus.oCharValid = oCharValid_q;
   assign bus.oBusy      = oBusy_q;

endmodule

// File: tb/tb_lcd_char_feeder.sv
// Directed bench for lcd_char_feeder: vector table plus startup, drop and reset sequences.
module tb_lcd_char_feeder;

   localparam int SC = 10;
   localparam int GC = 5;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   always #5 Clock = ~Clock;

   lcd_char_feeder_if bus0 ();
   lcd_char_feeder_if bus1 ();

   lcd_char_feeder #(.STARTUP_CYCLES(SC), .GAP_CYCLES(GC), .APPEND_SPACE(1'b1)) dut0 (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus0)
   );

   lcd_char_feeder #(.STARTUP_CYCLES(SC), .GAP_CYCLES(GC), .APPEND_SPACE(1'b0)) dut1 (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus1)
   );

   typedef struct {
      int              w;
      logic [7:0]      d;
      logic            m;
      int              n;
      logic [0:3][7:0] c;
      int              drop_at;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int w, input logic v, input logic [7:0] d, input logic m);
      if (w == 0) begin
         bus0.iValid = v; bus0.iData = d; bus0.iMode = m;
      end else begin
         bus1.iValid = v; bus1.iData = d; bus1.iMode = m;
      end
   endtask

   task automatic get(input int w, output logic cv, output logic [7:0] ch,
                      output logic busy, output logic dr);
      if (w == 0) begin
         cv = bus0.oCharValid; ch = bus0.oChar; busy = bus0.oBusy; dr = bus0.oDropped;
      end else begin
         cv = bus1.oCharValid; ch = bus1.oChar; busy = bus1.oBusy; dr = bus1.oDropped;
      end
   endtask

   // Called at a negedge with the block idle. Index i counts negedges after the accepting edge;
   // the value seen at i is what the LCD samples at edge t+i.
   task automatic run_vec(input vec_t v);
      logic cv, busy, dr;
      logic [7:0] ch, held;
      int last, k;
      bit exp_pulse;
      held = 8'h00;
      last = 9 + 6 * (v.n - 1);
      drive(v.w, 1'b1, v.d, v.m);
      #1;
      get(v.w, cv, ch, busy, dr);
      chk("accept_dropped", {31'd0, dr}, 32'd0);
      chk("accept_busy", {31'd0, busy}, 32'd0);
      for (int i = 1; i <= last + 7; i++) begin
         @(negedge Clock);
         if (i == v.drop_at) drive(v.w, 1'b1, 8'h12, 1'b0);
         else drive(v.w, 1'b0, 8'h00, 1'b0);
         #1;
         get(v.w, cv, ch, busy, dr);
         k = (i - 9) / 6;
         exp_pulse = (i >= 9) && ((i - 9) % 6 == 0) && (k < v.n);
         if (i == v.drop_at) chk("drop_pulse", {31'd0, dr}, 32'd1);
         if (exp_pulse) begin
            chk("pulse", {31'd0, cv}, 32'd1);
            chk("char", {24'd0, ch}, {24'd0, v.c[k]});
            held = ch;
         end else begin
            if (cv !== 1'b0) chk("no_pulse", {31'd0, cv}, 32'd0);
            if (i > 9 && ch !== held) chk("char_stable", {24'd0, ch}, {24'd0, held});
         end
         if (i == last + 5) chk("busy_before_idle", {31'd0, busy}, 32'd1);
         if (i == last + 6) chk("busy_idle", {31'd0, busy}, 32'd0);
      end
      drive(v.w, 1'b0, 8'h00, 1'b0);
   endtask

   // Called right after Reset falls at a negedge; k counts non-reset edges.
   task automatic watch_startup(input int w, input int strobe_at);
      logic cv, busy, dr;
      logic [7:0] ch;
      for (int k = 1; k <= SC + 3; k++) begin
         @(negedge Clock);
         drive(w, (k == strobe_at), 8'h55, 1'b0);
         #1;
         get(w, cv, ch, busy, dr);
         if (k == strobe_at) chk("startup_dropped", {31'd0, dr}, 32'd1);
         if (cv !== 1'b0) chk("startup_no_pulse", {31'd0, cv}, 32'd0);
         if (k == SC - 1) chk("startup_busy", {31'd0, busy}, 32'd1);
         if (k == SC) chk("startup_done", {31'd0, busy}, 32'd0);
      end
      drive(w, 1'b0, 8'h00, 1'b0);
   endtask

   vec_t vecs [8];
   vec_t v;

   initial begin
      logic cv, busy, dr;
      logic [7:0] ch;

      vecs[0] = '{0, 8'hFF, 1'b0, 4, {8'h32, 8'h35, 8'h35, 8'h20}, 0};
      vecs[1] = '{0, 8'hA7, 1'b1, 3, {8'h41, 8'h37, 8'h20, 8'h00}, 0};
      vecs[2] = '{0, 8'h00, 1'b0, 4, {8'h30, 8'h30, 8'h30, 8'h20}, 0};
      vecs[3] = '{0, 8'd100, 1'b0, 4, {8'h31, 8'h30, 8'h30, 8'h20}, 0};
      vecs[4] = '{0, 8'd7, 1'b0, 4, {8'h30, 8'h30, 8'h37, 8'h20}, 0};
      vecs[5] = '{0, 8'hFF, 1'b0, 4, {8'h32, 8'h35, 8'h35, 8'h20}, 17};
      vecs[6] = '{0, 8'hA7, 1'b1, 3, {8'h41, 8'h37, 8'h20, 8'h00}, 26};
      vecs[7] = '{1, 8'h0F, 1'b1, 2, {8'h30, 8'h46, 8'h00, 8'h00}, 0};

      drive(0, 1'b0, 8'h00, 1'b0);
      drive(1, 1'b0, 8'h00, 1'b0);
      Reset = 1'b1;
      repeat (3) @(negedge Clock);
      get(0, cv, ch, busy, dr);
      chk("reset_char", {24'd0, ch}, 32'd0);
      chk("reset_valid", {31'd0, cv}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd1);
      chk("reset_dropped", {31'd0, dr}, 32'd0);
      Reset = 1'b0;
      watch_startup(0, 3);

      for (int j = 0; j < 8; j++) begin
         @(negedge Clock);
         run_vec(vecs[j]);
      end

      // Reset in the gap after the first character.
      @(negedge Clock);
      drive(0, 1'b1, 8'hFF, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         @(negedge Clock);
         drive(0, 1'b0, 8'h00, 1'b0);
      end
      Reset = 1'b1;
      @(negedge Clock);
      get(0, cv, ch, busy, dr);
      chk("midreset_char", {24'd0, ch}, 32'd0);
      chk("midreset_valid", {31'd0, cv}, 32'd0);
      chk("midreset_busy", {31'd0, busy}, 32'd1);
      Reset = 1'b0;
      watch_startup(0, 5);
      @(negedge Clock);
      v = vecs[3];
      run_vec(v);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
